aes_mode_ctrl: RTL and testbench

Parametrised block-chaining controller that streams 128-bit blocks through one `aes_top` core in ECB, CBC or CTR mode, encrypt or decrypt. It sits between a valid/ready data stream and the core's `start`/`done` interface, holds key, IV and chaining state, and applies the mode XORs and counter increments around each core call.

---
 rtl/aes_mode_ctrl.sv | 160 ++++++++++++++++
 tb/tb_aes_mode_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: ECB/CBC/CTR block-chaining controller wrapped around a single
// aes_top core. One block is in flight at a time: accept, start core, wait for
// done, present result, then accept the next block.
module aes_mode_ctrl #(
  parameter int CTR_WIDTH = 32,
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [1:0]           cfg_mode,
  input  logic                 cfg_encrypt,
  input  logic [127:0]         cfg_key,
  input  logic [127:0]         cfg_iv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic                 out_last,
  output logic                 core_start,
  output logic                 core_encrypt,
  output logic [127:0]         core_data_in,
  output logic [127:0]         core_key_in,
  input  logic [127:0]         core_data_out,
  input  logic                 core_busy,
  input  logic                 core_done,
  output logic                 busy,
  output logic                 err,
  output logic [BLK_CNT_W-1:0] blk_count
);

  typedef enum logic [2:0] {S_IDLE, S_READY, S_START, S_WAIT, S_OUT} state_t;

  localparam logic [1:0] M_ECB = 2'b00;
  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CTR = 2'b10;

  state_t       state;
  logic [127:0] key_q;
  logic [127:0] chain;     // CBC previous ciphertext / CTR counter block
  logic [127:0] blk_q;     // latched input block
  logic [1:0]   mode_q;
  logic         enc_q;
  logic         last_q;
  logic [127:0] ctr_next;

  // Handshake strobes are pure decodes of the state register.
  assign in_ready   = (state == S_READY);
  assign out_valid  = (state == S_OUT);
  assign busy       = (state != S_IDLE);
  // Start may only fire while the core is free; it is high for the single
  // cycle that also advances START -> WAIT.
  assign core_start = (state == S_START) && !core_busy;

  // Counter increment touches only the low CTR_WIDTH bits, wrapping in place.
  always_comb begin
    ctr_next                = chain;
    ctr_next[CTR_WIDTH-1:0] = chain[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
  end

  // Session FSM: configuration, per-block core call and mode chaining.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      key_q        <= '0;
      chain        <= '0;
      blk_q        <= '0;
      mode_q       <= M_ECB;
      enc_q        <= 1'b0;
      last_q       <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      core_encrypt <= 1'b0;
      core_data_in <= '0;
      core_key_in  <= '0;
      err          <= 1'b0;
      blk_count    <= '0;
    end else begin
      // Reconfiguring mid-session is refused but flagged.
      if (cfg_load && state != S_IDLE) err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cfg_load) begin
            if (cfg_mode == 2'b11) begin
              err <= 1'b1;
            end else begin
              key_q     <= cfg_key;
              mode_q    <= cfg_mode;
              enc_q     <= cfg_encrypt;
              chain     <= cfg_iv;
              err       <= 1'b0;
              blk_count <= '0;
              state     <= S_READY;
            end
          end
        end
        S_READY: begin
          if (in_valid) begin
            blk_q       <= in_data;
            last_q      <= in_last;
            core_key_in <= key_q;
            // Core inputs are set up here so they are stable from START on.
            case (mode_q)
              M_CBC: begin
                core_data_in <= enc_q ? (in_data ^ chain) : in_data;
                core_encrypt <= enc_q;
              end
              M_CTR: begin
                core_data_in <= chain;
                core_encrypt <= 1'b1;
              end
              default: begin
                core_data_in <= in_data;
                core_encrypt <= enc_q;
              end
            endcase
            state <= S_START;
          end
        end
        S_START: begin
          if (!core_busy) state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            out_last <= last_q;
            case (mode_q)
              M_CBC: begin
                if (enc_q) begin
                  out_data <= core_data_out;
                  chain    <= core_data_out;
                end else begin
                  out_data <= core_data_out ^ chain;
                  chain    <= blk_q;
                end
              end
              M_CTR: begin
                out_data <= blk_q ^ core_data_out;
                chain    <= ctr_next;
              end
              default: out_data <= core_data_out;
            endcase
            state <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            blk_count <= blk_count + BLK_CNT_W'(1);
            out_last  <= 1'b0;
            state     <= last_q ? S_IDLE : S_READY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb_aes_mode_ctrl: scoreboard bench for aes_mode_ctrl. A behavioural core
// model stands in for aes_top using an invertible stand-in cipher; expected
// mode outputs are computed from the chaining equations over whole sessions.
module tb_aes_mode_ctrl;
  localparam int CW = 32;

  logic         clk = 0, rst = 1;
  logic         cfg_load = 0, cfg_encrypt = 0;
  logic [1:0]   cfg_mode = 0;
  logic [127:0] cfg_key = 0, cfg_iv = 0;
  logic         in_valid = 0, in_last = 0, in_ready;
  logic [127:0] in_data = 0;
  logic         out_valid, out_ready = 0, out_last;
  logic [127:0] out_data;
  logic         core_start, core_encrypt;
  logic [127:0] core_data_in, core_key_in;
  logic [127:0] core_data_out = 0;
  logic         core_busy = 0, core_done = 0;
  logic         busy, err;
  logic [15:0]  blk_count;

  aes_mode_ctrl #(.CTR_WIDTH(CW), .BLK_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
    .cfg_encrypt(cfg_encrypt), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_start(core_start), .core_encrypt(core_encrypt), .core_data_in(core_data_in),
    .core_key_in(core_key_in), .core_data_out(core_data_out), .core_busy(core_busy),
    .core_done(core_done), .busy(busy), .err(err), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [127:0] d; logic l; } exp_t;
  exp_t         exp_q[$];
  logic [127:0] got_q[$], core_log[$], sess_in[$], sess_exp[$];
  int tests = 0, fails = 0, exp_cnt = 0, force_lat = 0;
  bit stall = 0, aborted = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in block cipher: keyed rotate/add, exactly invertible.
  function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
    return (x << n) | (x >> (128 - n));
  endfunction
  function automatic logic [127:0] fenc(input logic [127:0] k, input logic [127:0] x);
    return rotl(x ^ k, 29) + {k[63:0], k[127:64]};
  endfunction
  function automatic logic [127:0] fdec(input logic [127:0] k, input logic [127:0] y);
    return rotl(y - {k[63:0], k[127:64]}, 99) ^ k;
  endfunction

  // Reference model: whole-session chaining equations over sess_in.
  task automatic build_exp(input logic [1:0] m, input logic e,
                           input logic [127:0] k, input logic [127:0] iv);
    logic [127:0] prev, c, ctr;
    prev = iv;
    sess_exp.delete();
    foreach (sess_in[i]) begin
      case (m)
        2'd0: sess_exp.push_back(e ? fenc(k, sess_in[i]) : fdec(k, sess_in[i]));
        2'd1: begin
          if (e) begin
            c = fenc(k, sess_in[i] ^ prev);
            sess_exp.push_back(c);
            prev = c;
          end else begin
            sess_exp.push_back(fdec(k, sess_in[i]) ^ prev);
            prev = sess_in[i];
          end
        end
        default: begin
          ctr = iv;
          ctr[CW-1:0] = iv[CW-1:0] + CW'(i);
          sess_exp.push_back(sess_in[i] ^ fenc(k, ctr));
        end
      endcase
    end
  endtask

  // Output handshake driver: random backpressure unless a stall is forced.
  initial forever begin
    @(posedge clk); #1;
    out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Core model: accepts a start, stays busy for a random latency, pulses done.
  initial begin
    logic [127:0] cd, ck;
    logic ce;
    int lat;
    forever begin
      @(negedge clk);
      if (core_start && !rst) begin
        cd = core_data_in; ck = core_key_in; ce = core_encrypt;
        core_log.push_back(cd);
        @(posedge clk); #1 core_busy = 1;
        lat = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
        repeat (lat) begin
          @(negedge clk);
          if (!aborted) check("core_data_in_stable", core_data_in, cd);
        end
        @(posedge clk); #1;
        core_done = 1;
        core_data_out = ce ? fenc(ck, cd) : fdec(ck, cd);
        @(posedge clk); #1;
        core_done = 0; core_busy = 0;
        core_data_out = {$urandom(), $urandom(), $urandom(), $urandom()};
        aborted = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (core_start) check("start_while_core_busy", core_busy, 0);
      if (out_valid && out_ready) begin
        check("in_ready_with_out_valid", in_ready, 0);
        check("blk_count", blk_count, exp_cnt);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.l);
        end
        got_q.push_back(out_data);
        exp_cnt++;
      end
    end
  end

  task automatic cfg(input logic [1:0] m, input logic e, input logic [127:0] k, input logic [127:0] iv);
    @(posedge clk); #1;
    cfg_load = 1; cfg_mode = m; cfg_encrypt = e; cfg_key = k; cfg_iv = iv;
    @(posedge clk); #1;
    cfg_load = 0;
    if (m != 2'b11) exp_cnt = 0;
  endtask

  task automatic send_block(input logic [127:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1; in_data = d; in_last = l;
    do begin
      @(negedge clk); n++;
    end while (!in_ready && n < 2000);
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while ((exp_q.size() != 0 || busy) && n < 2000);
    check("session_drained", (exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic run_session(input logic [1:0] m, input logic e,
                             input logic [127:0] k, input logic [127:0] iv);
    core_log.delete(); got_q.delete();
    cfg(m, e, k, iv);
    foreach (sess_in[i]) begin
      exp_q.push_back('{d: sess_exp[i], l: (i == sess_in.size() - 1)});
      send_block(sess_in[i], i == sess_in.size() - 1);
    end
    wait_idle();
    check("err_clear", err, 0);
  endtask

  task automatic reset_in_wait(input logic [127:0] k);
    int n;
    force_lat = 8;
    cfg(2'd0, 1'b1, k, '0);
    exp_q.push_back('{d: fenc(k, 128'h5), l: 1'b1});
    send_block(128'h5, 1'b1);
    n = 0;
    while (!core_busy && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 rst = 1; aborted = 1;
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #1 rst = 0;
    force_lat = 0;
  endtask

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] k, iv, d0, pts[$];
    logic [1:0] m;
    logic e;
    int nb, ov, n0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);     check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);     check("rst_out_data", out_data, 0);
    check("rst_core_start", core_start, 0); check("rst_core_encrypt", core_encrypt, 0);
    check("rst_core_data_in", core_data_in, 0); check("rst_core_key_in", core_key_in, 0);
    check("rst_busy", busy, 0);             check("rst_err", err, 0);
    check("rst_blk_count", blk_count, 0);

    // ECB encrypt single last block, then decrypt it back.
    sess_in = '{PT}; build_exp(2'd0, 1'b1, KEY, '0);
    run_session(2'd0, 1'b1, KEY, '0);
    check("ecb_blk_count", blk_count, 1);
    sess_in = got_q; sess_exp = '{PT};
    run_session(2'd0, 1'b0, KEY, '0);

    // CBC encrypt two blocks with IV 0, then decrypt round trip.
    pts = '{PT, 128'h0}; sess_in = pts; build_exp(2'd1, 1'b1, KEY, '0);
    run_session(2'd1, 1'b1, KEY, '0);
    if (got_q.size() == 2) check("cbc_blk2_is_ecb_of_blk1", got_q[1], fenc(KEY, got_q[0]));
    else check("cbc_out_count", got_q.size(), 2);
    sess_in = got_q; sess_exp = pts;
    run_session(2'd1, 1'b0, KEY, '0);

    // CTR: second counter block increments the low word only.
    sess_in = '{128'h0, 128'h0}; build_exp(2'd2, 1'b0, KEY, PT);
    run_session(2'd2, 1'b0, KEY, PT);
    if (core_log.size() >= 2) check("ctr_second_counter", core_log[1], 128'h00112233445566778899aabbccddef00);
    else check("ctr_core_calls", core_log.size(), 2);

    // CTR wrap of the low CW bits.
    iv = {96'hdeadbeef_01234567_89abcdef, 32'hffffffff};
    sess_in = '{128'h1, 128'h2}; build_exp(2'd2, 1'b1, KEY, iv);
    run_session(2'd2, 1'b1, KEY, iv);
    if (core_log.size() >= 2) check("ctr_wrap_counter", core_log[1], {iv[127:32], 32'h0});
    else check("ctr_wrap_core_calls", core_log.size(), 2);

    // Output stall with a refused cfg_load in the middle.
    stall = 1;
    core_log.delete();
    cfg(2'd1, 1'b1, KEY, 128'h77);
    exp_q.push_back('{d: fenc(KEY, PT ^ 128'h77), l: 1'b0});
    send_block(PT, 1'b0);
    n0 = 0;
    while (!out_valid && n0 < 100) begin @(negedge clk); n0++; end
    d0 = out_data; n0 = core_log.size();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cfg_load = (i == 4); cfg_mode = 2'd0; cfg_key = ~KEY;
      @(negedge clk);
      check("stall_out_data", out_data, d0);
      check("stall_in_ready", in_ready, 0);
    end
    cfg_load = 0;
    check("stall_err", err, 1); check("stall_busy", busy, 1);
    check("stall_no_restart", core_log.size(), n0);
    stall = 0;
    exp_q.push_back('{d: fenc(KEY, 128'h9 ^ fenc(KEY, PT ^ 128'h77)), l: 1'b1});
    send_block(128'h9, 1'b1);
    wait_idle();

    // Reserved mode in IDLE.
    cfg(2'b11, 1'b1, KEY, '0);
    @(negedge clk);
    check("mode11_err", err, 1); check("mode11_busy", busy, 0);

    // Reset during WAIT, stray done must not produce output.
    reset_in_wait(KEY);
    @(negedge clk);
    check("abort_busy", busy, 0); check("abort_out_valid", out_valid, 0);
    check("abort_core_data_in", core_data_in, 0); check("abort_err", err, 0);
    ov = 0;
    repeat (14) begin @(negedge clk); if (out_valid) ov++; end
    check("stray_done_no_output", ov, 0);

    // Reset during WAIT, then a new session while the core is still busy.
    reset_in_wait(~KEY);
    sess_in = '{PT}; build_exp(2'd0, 1'b1, ~KEY, '0);
    run_session(2'd0, 1'b1, ~KEY, '0);

    // Randomised sessions.
    for (int s = 0; s < 14; s++) begin
      m = 2'($urandom_range(0, 2)); e = 1'($urandom_range(0, 1));
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      iv = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) iv[31:0] = 32'hfffffffe;
      nb = $urandom_range(1, 4);
      sess_in.delete();
      for (int b = 0; b < nb; b++) sess_in.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      build_exp(m, e, k, iv);
      run_session(m, e, k, iv);
      check("rand_blk_count", blk_count, nb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
